// File: rtl/compressed_block_unpacker.sv
// rtl/compressed_block_unpacker.sv - header+payload word stream to parallel zero-compressed block
// Optional feature macro: UNPACKER_BLK_CNT_EN (adds blk_cnt / drop_cnt outputs)
module compressed_block_unpacker #(
  parameter int WORD_L     = 8,
  parameter int IN_PORT_L  = 4,
  parameter int OUT_PORT_L = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_L-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [OUT_PORT_L-1:0]         out_header,
  output logic [IN_PORT_L*WORD_L-1:0]   out_words,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          proto_err
`ifdef UNPACKER_BLK_CNT_EN
  ,
  output logic [15:0]                   blk_cnt,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int CW = $clog2(OUT_PORT_L + 1);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP, S_OUT} state_t;

  state_t                        state, state_nxt;
  logic [OUT_PORT_L-1:0]         hdr_reg;
  logic [IN_PORT_L*WORD_L-1:0]   buf_q;
  logic [CW-1:0]                 need;
  logic [CW-1:0]                 cnt;
  logic [CW-1:0]                 cnt_inc;
  logic [CW-1:0]                 hdr_pc;
  logic                          hdr_over;
  logic                          in_fire;
  logic                          out_fire;

  function automatic logic [CW-1:0] popcount(input logic [OUT_PORT_L-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < OUT_PORT_L; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign hdr_pc   = popcount(in_data[OUT_PORT_L-1:0]);
  assign hdr_over = (hdr_pc > CW'(IN_PORT_L));
  assign cnt_inc  = cnt + CW'(1);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (in_fire) begin
          if (hdr_pc == '0)   state_nxt = S_OUT;
          else if (hdr_over)  state_nxt = S_DROP;
          else                state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (in_fire && (cnt_inc == need)) state_nxt = S_OUT;
      S_DROP:    if (in_fire && (cnt_inc == need)) state_nxt = S_HDR;
      S_OUT:     if (out_fire) state_nxt = S_HDR;
      default:   state_nxt = S_HDR;
    endcase
  end

  // Outputs read the holding registers directly; those only change outside S_OUT.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_header = hdr_reg;
    out_words  = buf_q;
    if (rst) begin
      out_header = '0;
      out_words  = '0;
    end else begin
      in_ready  = (state != S_OUT);
      out_valid = (state == S_OUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_reg   <= '0;
      buf_q     <= '0;
      need      <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        S_HDR: begin
          if (in_fire) begin
            hdr_reg <= in_data[OUT_PORT_L-1:0];
            need    <= hdr_pc;
            cnt     <= '0;
            buf_q   <= '0;
            if (hdr_over) proto_err <= 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (in_fire) begin
            for (int i = 0; i < IN_PORT_L; i++) begin
              if (cnt == CW'(i)) buf_q[i*WORD_L +: WORD_L] <= in_data;
            end
            cnt <= cnt_inc;
          end
        end
        S_DROP: if (in_fire) cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

`ifdef UNPACKER_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (out_fire) blk_cnt <= blk_cnt + 16'd1;
      if ((state == S_HDR) && in_fire && hdr_over) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compressed_block_unpacker.sv
// tb/tb_compressed_block_unpacker.sv - directed self-checking bench for compressed_block_unpacker
// Honours UNPACKER_BLK_CNT_EN when defined.
module tb_compressed_block_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_header;
  logic [31:0] out_words;
  logic        out_valid;
  logic        out_ready;
  logic        proto_err;
`ifdef UNPACKER_BLK_CNT_EN
  logic [15:0] blk_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  compressed_block_unpacker #(.WORD_L(8), .IN_PORT_L(4), .OUT_PORT_L(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_header (out_header),
    .out_words  (out_words),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .proto_err  (proto_err)
`ifdef UNPACKER_BLK_CNT_EN
    ,
    .blk_cnt    (blk_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is accepted.
  task automatic send(input logic [7:0] w);
    int k;
    in_data  = w;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) chk("send_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_header", {24'd0, out_header}, 32'd0);
    chk("rst_out_words", out_words, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Basic block
    out_ready = 1'b1;
    send(8'h29); send(8'h11); send(8'h22);
    chk("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
    send(8'h33);
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_header", {24'd0, out_header}, 32'h29);
    chk("basic_words", out_words, 32'h00332211);
    chk("basic_proto_err", {31'd0, proto_err}, 32'd0);
    chk("basic_in_ready_out", {31'd0, in_ready}, 32'd0);
    step();
    chk("basic_valid_drop", {31'd0, out_valid}, 32'd0);

    // Empty block
    send(8'h00);
    chk("empty_valid", {31'd0, out_valid}, 32'd1);
    chk("empty_header", {24'd0, out_header}, 32'd0);
    chk("empty_words", out_words, 32'd0);
    step();
    chk("empty_in_ready_next", {31'd0, in_ready}, 32'd1);

    // Backpressure with junk offered on the input side
    out_ready = 1'b0;
    send(8'h0F); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    in_data = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_header", {24'd0, out_header}, 32'h0F);
      chk("bp_words", out_words, 32'hA4A3A2A1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_released", {31'd0, out_valid}, 32'd0);
`ifdef UNPACKER_BLK_CNT_EN
    chk("bp_blk_cnt", {16'd0, blk_cnt}, 32'd3);
`endif

    // Overflow headers: 0xFF (8 words) and 0x1F (5 words) are dropped
    send(8'hFF);
    chk("ovf_proto_err", {31'd0, proto_err}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i));
      chk("ovf_no_block", {31'd0, out_valid}, 32'd0);
    end
    send(8'h1F);
    for (int i = 0; i < 5; i++) begin
      send(8'h60 + 8'(i));
      chk("ovf5_no_block", {31'd0, out_valid}, 32'd0);
    end
    send(8'h01); send(8'h5A);
    chk("ovf_next_valid", {31'd0, out_valid}, 32'd1);
    chk("ovf_next_header", {24'd0, out_header}, 32'h01);
    chk("ovf_next_words", out_words, 32'h0000005A);
    chk("ovf_sticky", {31'd0, proto_err}, 32'd1);
`ifdef UNPACKER_BLK_CNT_EN
    chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif
    step();
`ifdef UNPACKER_BLK_CNT_EN
    chk("ovf_blk_cnt", {16'd0, blk_cnt}, 32'd4);
`endif

    // Gapped input
    send(8'h81);
    step();
    send(8'h7E);
    step();
    send(8'h01);
    chk("gap_valid", {31'd0, out_valid}, 32'd1);
    chk("gap_header", {24'd0, out_header}, 32'h81);
    chk("gap_words", out_words, 32'h0000017E);
    step();

    // Reset in the middle of a block
    send(8'h07); send(8'h99);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_proto_err", {31'd0, proto_err}, 32'd0);
    send(8'h02); send(8'h44);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_header", {24'd0, out_header}, 32'h02);
    chk("post_rst_words", out_words, 32'h00000044);
    step();
`ifdef UNPACKER_BLK_CNT_EN
    chk("post_rst_blk_cnt", {16'd0, blk_cnt}, 32'd1);
    chk("post_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
